// File: rtl/soft_mem_pkg.sv
// Shared types and sizing helpers for the soft-memory port arbiter.
package soft_mem_pkg;

  typedef enum logic {
    ARB_INS  = 1'b0,
    ARB_DATA = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic      valid;
    arb_port_e port;
    logic      is_read;
    logic      err;
  } resp_t;

  function automatic int calc_depth(input int size_kb, input int word_bytes);
    return size_kb * 1024 / word_bytes;
  endfunction

  // One spare bit so an index equal to DEPTH is still representable.
  function automatic int calc_idx_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/soft_mem_prio_sel.sv
// Two-input grant selector. SOFT_MEM_ARB_RR_EN selects round-robin; otherwise data wins.
module soft_mem_prio_sel
  import soft_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ins_req_i,
  input  logic data_req_i,
  output logic ins_gnt_o,
  output logic data_gnt_o
);

`ifdef SOFT_MEM_ARB_RR_EN
  arb_port_e prio_q;
  arb_port_e prio_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= ARB_INS;
    else         prio_q <= prio_d;
  end

  // The preferred port only changes hands when both ports actually collide.
  always_comb begin
    prio_d     = prio_q;
    ins_gnt_o  = ins_req_i;
    data_gnt_o = data_req_i;
    if (ins_req_i && data_req_i) begin
      if (prio_q == ARB_INS) begin
        data_gnt_o = 1'b0;
        prio_d     = ARB_DATA;
      end else begin
        ins_gnt_o  = 1'b0;
        prio_d     = ARB_INS;
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok  = clk_i ^ rst_ni;
  assign data_gnt_o = data_req_i;
  assign ins_gnt_o  = ins_req_i & ~data_req_i;
`endif

endmodule

// File: rtl/soft_mem_port_arbiter.sv
// Shares one single-port soft RAM between instruction-fetch and data ports.
// Optional round-robin arbitration via SOFT_MEM_ARB_RR_EN (default: data port priority).
module soft_mem_port_arbiter
  import soft_mem_pkg::*;
#(
  parameter int WORD_SIZE_BYTE = 4,
  parameter int SIZE_IN_KB     = 8,
  parameter int ADDR_WIDTH     = 32,
  localparam int DEPTH  = calc_depth(SIZE_IN_KB, WORD_SIZE_BYTE),
  localparam int IDX_W  = calc_idx_w(DEPTH),
  localparam int WORD_W = WORD_SIZE_BYTE * 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ins_req_i,
  input  logic [ADDR_WIDTH-1:0]     ins_addr_i,
  output logic                      ins_gnt_o,
  output logic                      ins_rvalid_o,
  output logic [WORD_W-1:0]         ins_rdata_o,
  output logic                      ins_err_o,
  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_addr_i,
  input  logic                      data_we_i,
  input  logic [WORD_SIZE_BYTE-1:0] data_be_i,
  input  logic [WORD_W-1:0]         data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [WORD_W-1:0]         data_rdata_o,
  output logic                      data_err_o,
  output logic                      mem_ena_o,
  output logic [IDX_W-1:0]          mem_addr_o,
  output logic [WORD_SIZE_BYTE-1:0] mem_wea_o,
  output logic [WORD_W-1:0]         mem_dina_o,
  input  logic [WORD_W-1:0]         mem_douta_i
);

  localparam int OFF_W  = $clog2(WORD_SIZE_BYTE);
  localparam int WIDX_W = ADDR_WIDTH - OFF_W;

  logic              any_gnt;
  logic [WIDX_W-1:0] sel_widx;
  logic              in_range;
  logic              unused_ok;
  resp_t             resp_d;
  resp_t             resp_p1;
  logic              vld_p1;
  logic              read_ok_p1;

  soft_mem_prio_sel u_prio_sel (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ins_req_i  (ins_req_i),
    .data_req_i (data_req_i),
    .ins_gnt_o  (ins_gnt_o),
    .data_gnt_o (data_gnt_o)
  );

  // Stage T: combinational grant and memory drive
  assign any_gnt   = ins_gnt_o | data_gnt_o;
  assign sel_widx  = data_gnt_o ? data_addr_i[ADDR_WIDTH-1:OFF_W] : ins_addr_i[ADDR_WIDTH-1:OFF_W];
  assign in_range  = (sel_widx < WIDX_W'(DEPTH));
  assign unused_ok = ^{ins_addr_i[OFF_W-1:0], data_addr_i[OFF_W-1:0], sel_widx[WIDX_W-1:IDX_W]};

  assign mem_ena_o  = any_gnt & in_range;
  assign mem_addr_o = sel_widx[IDX_W-1:0];
  assign mem_wea_o  = (data_gnt_o && data_we_i) ? data_be_i : '0;
  assign mem_dina_o = data_wdata_i;

  always_comb begin
    resp_d         = '0;
    resp_d.valid   = any_gnt;
    resp_d.port    = data_gnt_o ? ARB_DATA : ARB_INS;
    resp_d.is_read = data_gnt_o ? ~data_we_i : 1'b1;
    resp_d.err     = any_gnt & ~in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) resp_p1 <= '0;
    else         resp_p1 <= resp_d;
  end

  // Stage T+1: response; read data passes straight through from the RAM
  assign vld_p1     = resp_p1.valid;
  assign read_ok_p1 = resp_p1.is_read & ~resp_p1.err;

  assign ins_rvalid_o  = vld_p1 & (resp_p1.port == ARB_INS);
  assign data_rvalid_o = vld_p1 & (resp_p1.port == ARB_DATA);
  assign ins_err_o     = ins_rvalid_o & resp_p1.err;
  assign data_err_o    = data_rvalid_o & resp_p1.err;
  assign ins_rdata_o   = (ins_rvalid_o && read_ok_p1) ? mem_douta_i : '0;
  assign data_rdata_o  = (data_rvalid_o && read_ok_p1) ? mem_douta_i : '0;

endmodule

// File: tb/tb_soft_mem_port_arbiter.sv
// Self-checking bench for soft_mem_port_arbiter: vector table, corner sequences, scoreboard.
module tb_soft_mem_port_arbiter;

  localparam int WSB   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;
  localparam int IDX_W = 12;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             ins_req_i;
  logic [AW-1:0]    ins_addr_i;
  logic             ins_gnt_o, ins_rvalid_o, ins_err_o;
  logic [DW-1:0]    ins_rdata_o;
  logic             data_req_i, data_we_i;
  logic [AW-1:0]    data_addr_i;
  logic [WSB-1:0]   data_be_i;
  logic [DW-1:0]    data_wdata_i;
  logic             data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0]    data_rdata_o;
  logic             mem_ena_o;
  logic [IDX_W-1:0] mem_addr_o;
  logic [WSB-1:0]   mem_wea_o;
  logic [DW-1:0]    mem_dina_o;
  logic [DW-1:0]    mem_douta_i;

  always #5 clk_i = ~clk_i;

  soft_mem_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_gnt_o(ins_gnt_o),
    .ins_rvalid_o(ins_rvalid_o), .ins_rdata_o(ins_rdata_o), .ins_err_o(ins_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_ena_o(mem_ena_o), .mem_addr_o(mem_addr_o), .mem_wea_o(mem_wea_o),
    .mem_dina_o(mem_dina_o), .mem_douta_i(mem_douta_i)
  );

  // Stand-in for the soft RAM: one-cycle read latency, byte writes.
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge clk_i) begin
    if (mem_ena_o) begin
      for (int b = 0; b < WSB; b++)
        if (mem_wea_o[b]) mem_arr[mem_addr_o[IDX_W-2:0]][8*b +: 8] <= mem_dina_o[8*b +: 8];
      mem_douta_i <= mem_arr[mem_addr_o[IDX_W-2:0]];
    end
  end

  // Reference memory, updated in grant order
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          port_data;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  int   n_vec = 0;
  int   n_bad = 0;
  logic tb_ptr_data = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic          m_ei, m_ed, m_wr, m_err;
  logic [AW-1:0] m_addr;
  logic [29:0]   m_widx;
  exp_t          m_e;

  always @(negedge clk_i) begin
    if (mon_en && rst_ni) begin
      if (sb_q.size() > 0) begin
        m_e = sb_q.pop_front();
        check("rsp_ins_rvalid", ins_rvalid_o, !m_e.port_data);
        check("rsp_data_rvalid", data_rvalid_o, m_e.port_data);
        if (m_e.port_data) begin
          check("rsp_data_rdata", data_rdata_o, m_e.rdata);
          check("rsp_data_err", data_err_o, m_e.err);
        end else begin
          check("rsp_ins_rdata", ins_rdata_o, m_e.rdata);
          check("rsp_ins_err", ins_err_o, m_e.err);
        end
      end else begin
        check("idle_rvalid", {ins_rvalid_o, data_rvalid_o}, 2'b00);
      end
`ifdef SOFT_MEM_ARB_RR_EN
      if (ins_req_i && data_req_i) begin
        m_ed = tb_ptr_data;
        m_ei = !tb_ptr_data;
        tb_ptr_data = !tb_ptr_data;
      end else begin
        m_ed = data_req_i;
        m_ei = ins_req_i;
      end
`else
      m_ed = data_req_i;
      m_ei = ins_req_i && !data_req_i;
`endif
      check("gnt", {ins_gnt_o, data_gnt_o}, {m_ei, m_ed});
      if (m_ei || m_ed) begin
        m_addr = m_ed ? data_addr_i : ins_addr_i;
        m_widx = m_addr[AW-1:2];
        m_err  = (m_widx >= 30'(DEPTH));
        m_wr   = m_ed && data_we_i;
        if (!m_err && m_wr)
          for (int b = 0; b < WSB; b++)
            if (data_be_i[b]) ref_mem[m_widx[10:0]][8*b +: 8] = data_wdata_i[8*b +: 8];
        m_e.port_data = m_ed;
        m_e.err       = m_err;
        m_e.rdata     = (!m_err && !m_wr) ? ref_mem[m_widx[10:0]] : '0;
        sb_q.push_back(m_e);
      end
    end
  end

  typedef struct {
    logic           ireq;
    logic [AW-1:0]  iaddr;
    logic           dreq;
    logic [AW-1:0]  daddr;
    logic           we;
    logic [WSB-1:0] be;
    logic [DW-1:0]  wdata;
    logic           e_igafter;
    logic           e_dg;
    logic           e_ena;
    logic [WSB-1:0] e_wea;
    logic [IDX_W-1:0] e_addr;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h2000 + (32'($urandom_range(0, 3)) << 2);
    return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic drive_idle();
    ins_req_i = 0; ins_addr_i = 0; data_req_i = 0; data_addr_i = 0;
    data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
  endtask

  logic          ip, dp, dwe;
  logic [AW-1:0] ia, da;
  logic [DW-1:0] dw;
  logic [3:0]    dbe;
  int            ng_i, ng_d;

  initial begin
    vecs[0] = '{1, 32'h10,   0, 32'h0,    0, 4'h0, 32'h0,        1, 0, 1, 4'h0, 12'd4};
    vecs[1] = '{0, 32'h0,    1, 32'h20,   1, 4'h3, 32'hAABBCCDD, 0, 1, 1, 4'h3, 12'd8};
    vecs[2] = '{0, 32'h0,    1, 32'h20,   0, 4'h0, 32'h0,        0, 1, 1, 4'h0, 12'd8};
    vecs[3] = '{0, 32'h0,    1, 32'h2000, 0, 4'h0, 32'h0,        0, 1, 0, 4'h0, 12'd0};
    vecs[4] = '{0, 32'h0,    0, 32'h0,    0, 4'h0, 32'h0,        0, 0, 0, 4'h0, 12'd0};
    vecs[5] = '{0, 32'h0,    1, 32'h31,   1, 4'h0, 32'hFFFFFFFF, 0, 1, 1, 4'h0, 12'd12};
    vecs[6] = '{1, 32'h3FFC, 0, 32'h0,    0, 4'h0, 32'h0,        1, 0, 0, 4'h0, 12'd0};
    vecs[7] = '{0, 32'h0,    1, 32'h4000, 1, 4'hF, 32'h12345678, 0, 1, 0, 4'hF, 12'd0};
    vecs[8] = '{1, 32'h22,   0, 32'h0,    0, 4'h0, 32'h0,        1, 0, 1, 4'h0, 12'd8};

    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
      ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    end
    mem_arr[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    mem_arr[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

    rst_ni = 0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rvalid", {ins_rvalid_o, data_rvalid_o}, 2'b00);
    check("rst_err", {ins_err_o, data_err_o}, 2'b00);
    check("rst_ins_rdata", ins_rdata_o, 32'h0);
    check("rst_data_rdata", data_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    mon_en = 1;

    // Vector table: single-port cycles, responses checked by the scoreboard
    for (int v = 0; v < 9; v++) begin
      ins_req_i = vecs[v].ireq;  ins_addr_i = vecs[v].iaddr;
      data_req_i = vecs[v].dreq; data_addr_i = vecs[v].daddr;
      data_we_i = vecs[v].we;    data_be_i = vecs[v].be;
      data_wdata_i = vecs[v].wdata;
      @(negedge clk_i); #1;
      check($sformatf("v%0d_ins_gnt", v), ins_gnt_o, vecs[v].e_igafter);
      check($sformatf("v%0d_data_gnt", v), data_gnt_o, vecs[v].e_dg);
      check($sformatf("v%0d_ena", v), mem_ena_o, vecs[v].e_ena);
      check($sformatf("v%0d_wea", v), mem_wea_o, vecs[v].e_wea);
      if (vecs[v].e_ena) check($sformatf("v%0d_addr", v), mem_addr_o, vecs[v].e_addr);
      @(posedge clk_i); #1;
    end
    drive_idle();
    @(posedge clk_i); #1;

    // Both ports requesting for four cycles
    ng_i = 0; ng_d = 0;
    ins_req_i = 1; ins_addr_i = 32'h20;
    data_req_i = 1; data_addr_i = 32'h10; data_we_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i); #1;
      ng_i += int'(ins_gnt_o);
      ng_d += int'(data_gnt_o);
      @(posedge clk_i); #1;
    end
`ifdef SOFT_MEM_ARB_RR_EN
    check("conflict_ins_gnts", ng_i, 2);
    check("conflict_data_gnts", ng_d, 2);
`else
    check("conflict_ins_gnts", ng_i, 0);
    check("conflict_data_gnts", ng_d, 4);
`endif
    drive_idle();
    @(posedge clk_i); #1;

    // Reset between grant and response
    ins_req_i = 1; ins_addr_i = 32'h10;
    @(negedge clk_i); #1;
    check("rst_mid_gnt", ins_gnt_o, 1'b1);
    rst_ni = 0;
    sb_q.delete();
    tb_ptr_data = 1'b0;
    ins_req_i = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_mid_ins_rvalid", ins_rvalid_o, 1'b0);
    check("rst_mid_data_rvalid", data_rvalid_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    ins_req_i = 1; ins_addr_i = 32'h20;
    data_req_i = 1; data_addr_i = 32'h10; data_we_i = 0;
    @(negedge clk_i); #1;
`ifdef SOFT_MEM_ARB_RR_EN
    check("post_rst_conflict", {ins_gnt_o, data_gnt_o}, 2'b10);
`else
    check("post_rst_conflict", {ins_gnt_o, data_gnt_o}, 2'b01);
`endif
    @(posedge clk_i); #1;
    drive_idle();
    @(posedge clk_i); #1;

    // Back-to-back random traffic; requesters hold until granted
    ip = 0; dp = 0; ia = 0; da = 0; dwe = 0; dw = 0; dbe = 0;
    for (int c = 0; c < 16; c++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1; ia = rand_addr();
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; da = rand_addr(); dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom); dw = $urandom;
      end
      ins_req_i = ip; ins_addr_i = ia;
      data_req_i = dp; data_addr_i = da; data_we_i = dwe;
      data_be_i = dbe; data_wdata_i = dw;
      @(negedge clk_i); #1;
      if (ins_gnt_o) ip = 0;
      if (data_gnt_o) dp = 0;
      @(posedge clk_i); #1;
    end
    drive_idle();
    repeat (2) @(posedge clk_i);
    #1;
    check("sb_drained", sb_q.size(), 0);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
